// File: rtl/bsr_chain.sv
// Parametrised boundary-scan register chain: shift/capture stage, update stage,
// one-bit bypass, shift-length counter and sticky partial-shift error flag.
module bsr_chain #(
  parameter int unsigned             WIDTH      = 4,
  parameter logic [WIDTH-1:0]        SAFE_VALUE = {WIDTH{1'b0}},
  parameter int unsigned             CW         = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             tdi,
  output logic             tdo,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             sel,
  input  logic             bypass,
  output logic [CW-1:0]    shift_cnt,
  output logic             shift_full,
  output logic             partial_err
);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] ur_q, ur_d;
  logic             byp_q, byp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             perr_q, perr_d;
  logic             cnt_at_max;
  logic             cnt_partial;

  assign cnt_at_max  = (cnt_q == CW'(WIDTH));
  assign cnt_partial = (cnt_q != CW'(0)) && !cnt_at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q   <= '0;
      ur_q   <= SAFE_VALUE;
      byp_q  <= 1'b0;
      cnt_q  <= '0;
      perr_q <= 1'b0;
    end else begin
      sr_q   <= sr_d;
      ur_q   <= ur_d;
      byp_q  <= byp_d;
      cnt_q  <= cnt_d;
      perr_q <= perr_d;
    end
  end

  // Next state; update samples the pre-edge shift register, capture clear beats error set.
  always_comb begin
    sr_d   = sr_q;
    ur_d   = ur_q;
    byp_d  = byp_q;
    cnt_d  = cnt_q;
    perr_d = perr_q;
    if (!bypass) begin
      if (capture) begin
        sr_d  = data_in;
        cnt_d = '0;
      end else if (shift) begin
        sr_d = {tdi, sr_q[WIDTH-1:1]};
        if (!cnt_at_max) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      if (update) begin
        ur_d = sr_q;
        if (cnt_partial) begin
          perr_d = 1'b1;
        end
      end
    end else begin
      if (capture) begin
        byp_d = 1'b0;
      end else if (shift) begin
        byp_d = tdi;
      end
    end
    if (capture) begin
      perr_d = 1'b0;
    end
  end

  assign data_out    = sel ? ur_q : data_in;
  assign tdo         = bypass ? byp_q : sr_q[0];
  assign shift_cnt   = cnt_q;
  assign shift_full  = cnt_at_max;
  assign partial_err = perr_q;

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_bsr_chain;

  localparam int unsigned W  = 4;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [W-1:0] SAFE = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [W-1:0]  data_out;
  logic          tdi, tdo;
  logic          capture, shift, update, sel, bypass;
  logic [CW-1:0] shift_cnt;
  logic          shift_full, partial_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: scan chain as a bit queue, index 0 is the tdo end.
  bit           m_sr[$];
  logic [W-1:0] m_ur;
  bit           m_byp;
  int           m_cnt;
  bit           m_perr;

  bsr_chain #(.WIDTH(W), .SAFE_VALUE(SAFE)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
    .tdi(tdi), .tdo(tdo), .capture(capture), .shift(shift), .update(update),
    .sel(sel), .bypass(bypass), .shift_cnt(shift_cnt), .shift_full(shift_full),
    .partial_err(partial_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] sr_vec();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W; i++) v[i] = m_sr[i];
    return v;
  endfunction

  task automatic model_reset();
    m_sr = {};
    for (int i = 0; i < W; i++) m_sr.push_back(1'b0);
    m_ur   = SAFE;
    m_byp  = 1'b0;
    m_cnt  = 0;
    m_perr = 1'b0;
  endtask

  task automatic model_edge();
    logic [W-1:0] pre_sr  = sr_vec();
    int           pre_cnt = m_cnt;
    if (!bypass) begin
      if (capture) begin
        m_sr = {};
        for (int i = 0; i < W; i++) m_sr.push_back(data_in[i]);
        m_cnt = 0;
      end else if (shift) begin
        void'(m_sr.pop_front());
        m_sr.push_back(tdi);
        m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
      end
      if (update) begin
        m_ur = pre_sr;
        if (pre_cnt > 0 && pre_cnt < W) m_perr = 1'b1;
      end
    end else begin
      if (capture)    m_byp = 1'b0;
      else if (shift) m_byp = tdi;
    end
    if (capture) m_perr = 1'b0;
  endtask

  task automatic check_all(input string pfx);
    chk({pfx, ".data_out"}, 64'(data_out), 64'(sel ? m_ur : data_in));
    chk({pfx, ".tdo"}, 64'(tdo), 64'(bypass ? m_byp : m_sr[0]));
    chk({pfx, ".cnt"}, 64'(shift_cnt), 64'(m_cnt));
    chk({pfx, ".full"}, 64'(shift_full), 64'(m_cnt == W));
    chk({pfx, ".perr"}, 64'(partial_err), 64'(m_perr));
  endtask

  // One clock edge with the given controls, then check against the model.
  task automatic step(input bit c, input bit s, input bit u, input bit t, input string pfx);
    capture = c; shift = s; update = u; tdi = t;
    @(posedge clk);
    model_edge();
    #1;
    check_all(pfx);
    capture = 1'b0; shift = 1'b0; update = 1'b0;
  endtask

  initial begin
    bit exp_tdo [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit seq [3]     = '{1'b1, 1'b0, 1'b1};
    bit pat [4]     = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [CW-1:0] cnt_keep;

    rst = 1'b1; data_in = 4'h5; sel = 1'b0; bypass = 1'b0;
    capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    model_reset();
    #12;
    // Scenario 1: reset values
    chk("s1.data_out_normal", 64'(data_out), 64'h5);
    chk("s1.tdo", 64'(tdo), 64'h0);
    chk("s1.cnt", 64'(shift_cnt), 64'h0);
    chk("s1.perr", 64'(partial_err), 64'h0);
    sel = 1'b1; #1;
    chk("s1.data_out_safe", 64'(data_out), 64'(SAFE));
    @(negedge clk); rst = 1'b0; sel = 1'b0;

    // Scenario 2: capture then shift ones through
    data_in = 4'hA;
    step(1, 0, 0, 0, "s2.cap");
    chk("s2.tdo0", 64'(tdo), 64'(exp_tdo[0]));
    for (int i = 1; i <= 4; i++) begin
      step(0, 1, 0, 1, "s2.sh");
      chk($sformatf("s2.tdo%0d", i), 64'(tdo), 64'(exp_tdo[i]));
    end
    chk("s2.cnt4", 64'(shift_cnt), 64'd4);
    chk("s2.full", 64'(shift_full), 64'd1);
    step(0, 1, 0, 1, "s2.sh5");
    chk("s2.cnt_sat", 64'(shift_cnt), 64'd4);

    // Scenario 3: update and mode select
    step(0, 0, 1, 0, "s3.upd");
    sel = 1'b1; data_in = 4'h3; #1;
    chk("s3.test_mode", 64'(data_out), 64'hF);
    chk("s3.no_perr", 64'(partial_err), 64'h0);
    sel = 1'b0; #1;
    chk("s3.normal_mode", 64'(data_out), 64'h3);

    // Scenario 4: partial shift error
    data_in = 4'h0; sel = 1'b1;
    step(1, 0, 0, 0, "s4.cap");
    step(0, 1, 0, 1, "s4.sh");
    step(0, 1, 0, 1, "s4.sh");
    step(0, 0, 1, 0, "s4.upd");
    chk("s4.ur_C", 64'(data_out), 64'hC);
    chk("s4.perr_set", 64'(partial_err), 64'h1);
    step(0, 1, 0, 0, "s4.sh_sticky");
    chk("s4.perr_sticky", 64'(partial_err), 64'h1);
    step(1, 0, 0, 0, "s4.cap_clr");
    chk("s4.perr_clr", 64'(partial_err), 64'h0);
    step(0, 1, 0, 1, "s4.sh");
    step(0, 1, 0, 1, "s4.sh");
    data_in = 4'h5;
    step(1, 0, 1, 0, "s4.cap_upd");
    chk("s4.cap_upd_ur", 64'(data_out), 64'hC);
    chk("s4.cap_upd_perr", 64'(partial_err), 64'h0);

    // Scenario 5: bypass path
    bypass = 1'b1;
    cnt_keep = shift_cnt;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, seq[i], "s5.byp");
      chk($sformatf("s5.tdo%0d", i), 64'(tdo), 64'(seq[i]));
    end
    step(0, 0, 1, 0, "s5.upd");
    chk("s5.ur_hold", 64'(data_out), 64'hC);
    chk("s5.cnt_hold", 64'(shift_cnt), 64'(cnt_keep));
    bypass = 1'b0; #1;
    chk("s5.tdo_sr0", 64'(tdo), 64'h1);

    // Scenario 6: reset mid-shift
    data_in = 4'h0;
    step(1, 0, 0, 0, "s6.cap");
    step(0, 1, 0, 1, "s6.sh");
    step(0, 1, 0, 1, "s6.sh");
    @(negedge clk); rst = 1'b1; model_reset(); #1;
    chk("s6.rst_data_out", 64'(data_out), 64'(SAFE));
    chk("s6.rst_tdo", 64'(tdo), 64'h0);
    chk("s6.rst_cnt", 64'(shift_cnt), 64'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) step(0, 1, 0, pat[i], "s6.sh");
    step(0, 0, 1, 0, "s6.upd");
    chk("s6.ur_D", 64'(data_out), 64'hD);
    chk("s6.perr", 64'(partial_err), 64'h0);

    // Randomized traffic against the model, with occasional async resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        @(negedge clk); rst = 1'b1; model_reset(); #1;
        check_all("rnd.rst");
        @(negedge clk); rst = 1'b0;
      end
      data_in = W'($urandom);
      sel     = 1'($urandom);
      bypass  = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 5) == 0, 1'($urandom), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bsr_chain.md
# bsr_chain

Parametrised boundary-scan register chain of WIDTH cells, replacing hand-instantiated single-bit `bsr` cells. Each cell has a shift/capture stage and an update stage. A per-chain mode select drives either functional data or the updated test vector onto the pins. Beyond the single cell, the block adds:
- a synchronous update stage,
- a one-bit bypass path,
- a shift-length counter with a partial-shift error flag,
- a parametrised safe reset value for the update stage.

It sits between core I/O and pads, with tdi/tdo chained to neighbouring scan segments.

## Interface
- WIDTH, 4, number of boundary cells; legal range 2..64.
- SAFE_VALUE, {WIDTH{1'b0}}, reset value of the update register.
- CW, $clog2(WIDTH+1), width of shift_cnt (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  WIDTH  functional data from core.
- data_out  out  WIDTH  data to pads.
- tdi  in  1  scan input; enters cell WIDTH-1.
- tdo  out  1  scan output.
- capture  in  1  load shift register from data_in.
- shift  in  1  shift chain one position toward bit 0.
- update  in  1  transfer shift register into update register.
- sel  in  1  0 = normal (data_out = data_in), 1 = test (data_out = update register).
- bypass  in  1  route scan through the single bypass flop.
- shift_cnt  out  CW  bits shifted since last capture, saturating at WIDTH.
- shift_full  out  1  shift_cnt == WIDTH.
- partial_err  out  1  sticky: an update occurred with 0 < shift_cnt < WIDTH.

## Operation
- State:
  - sr[WIDTH-1:0]: shift register.
  - ur[WIDTH-1:0]: update register.
  - byp: bypass flop.
  - cnt: shift counter.
  - perr: partial-shift error flag.
- Reset (async, immediate, no clock required): sr=0, ur=SAFE_VALUE, byp=0, cnt=0, perr=0.
- Non-bypass (bypass=0), per edge, with priority capture > shift:
  - capture: sr <= data_in; cnt <= 0; perr <= 0.
  - shift (no capture): sr <= {tdi, sr[WIDTH-1:1]}; cnt <= min(cnt+1, WIDTH).
  - Neither: sr and cnt hold.
- Bypass (bypass=1):
  - capture: byp <= 0.
  - shift: byp <= tdi.
  - sr and cnt hold in both cases.
  - capture still clears perr.
- update:
  - Non-bypass: ur <= sr, using the pre-edge value of sr, independent of a capture or shift in the same cycle.
  - Bypass: ur holds.
  - Non-bypass update with 0 < cnt < WIDTH (pre-edge): perr <= 1.
  - If capture occurs on the same edge, the capture clear wins (perr = 0).
- Outputs (combinational from registers):
  - data_out = sel ? ur : data_in.
  - tdo = bypass ? byp : sr[0].
  - shift_cnt = cnt.
  - shift_full = (cnt == WIDTH).
  - partial_err = perr.
- Changing bypass mid-sequence is legal. The unused path holds its state. tdo switches combinationally.

## Timing
- Capture/shift/update: one-cycle effect, visible after the rising edge.
- data_out: combinational from sel and data_in; one cycle after the update edge in test mode.
- Scan latency:
  - tdi reaches tdo after WIDTH shift edges (non-bypass).
  - tdi reaches tdo after 1 shift edge (bypass).
- Counter saturates at WIDTH; further shifts keep shift_full=1 and do not wrap.
- cnt=0 at update (no shift since capture) is not an error.
- Reset asserted mid-shift aborts the sequence. data_out in test mode shows SAFE_VALUE immediately.
- First edge after reset deassertion acts normally. There is no internal synchroniser on rst.

## Test plan
1. Reset, sel=0, data_in=4'h5 -> data_out=4'h5, tdo=0, shift_cnt=0, partial_err=0. Then sel=1 -> data_out=SAFE_VALUE (4'h0).
2. capture with data_in=4'hA, then 4 shifts with tdi=1 -> tdo after capture and after each shift: 0,1,0,1,1. Final sr=4'hF, shift_cnt=4, shift_full=1; a 5th shift keeps shift_cnt=4.
3. After scenario 2, update, sel=1, data_in=4'h3 -> data_out=4'hF. Then sel=0 -> data_out=4'h3.
4. capture (data_in=4'h0), 2 shifts with tdi=1, update -> ur=4'hC, partial_err=1 (sticky through further shifts). Next capture -> partial_err=0. Simultaneous capture+update -> ur gets pre-edge sr, partial_err=0.
5. bypass=1, shift tdi sequence 1,0,1 -> tdo 1,0,1 each one edge later. sr, shift_cnt and ur unchanged; update has no effect on ur.
6. Mid-shift (after 2 of 4 shifts), assert rst between edges with sel=1 -> data_out=SAFE_VALUE, tdo=0, shift_cnt=0 before the next edge. After release, a full 4-shift + update sequence loads correctly.
